// File: rtl/program_loader.sv
// Boot-time program loader: receives a counted, checksummed byte stream, assembles
// instructions, writes them to program memory from address 0 and gates core halt.
module program_loader #(
    parameter int INST_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [INST_WIDTH-1:0] mem_data,
    output logic                  core_halt,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int BPI    = INST_WIDTH / 8;
    localparam int BIDX_W = (BPI > 1) ? $clog2(BPI) : 1;
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BPI - 1);
    localparam logic [16:0]       MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_LO = 3'd1,
        S_CNT_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [15:0]            count_r;
    logic [15:0]            count_s;
    logic [7:0]             csum_r;
    logic [ADDR_WIDTH-1:0]  word_idx_r;
    logic [BIDX_W-1:0]      byte_idx_r;
    logic [INST_WIDTH-1:0]  word_r;
    logic [INST_WIDTH-1:0]  word_s;
    logic                   rx_ready_s;
    logic                   xfer_s;
    logic                   arm_s;
    logic                   last_byte_s;
    logic                   last_word_s;
    logic                   mem_write_r;
    logic [ADDR_WIDTH-1:0]  mem_address_r;
    logic [INST_WIDTH-1:0]  mem_data_r;
    logic                   core_halt_r;
    logic                   load_done_r;
    logic                   load_error_r;

    // Handshake and stream-position decode.
    always_comb begin
        rx_ready_s = 1'b0;
        case (state_r)
            S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK: rx_ready_s = 1'b1;
            default:                             rx_ready_s = 1'b0;
        endcase
        xfer_s      = rx_valid & rx_ready_s;
        arm_s       = start & ((state_r == S_IDLE) | (state_r == S_DONE) | (state_r == S_ERROR));
        count_s     = {rx_data, count_r[7:0]};
        last_byte_s = (byte_idx_r == LAST_BYTE);
        // 17-bit compare so a full 2**ADDR_WIDTH-word load terminates correctly.
        last_word_s = ((17'(word_idx_r) + 17'd1) == {1'b0, count_r});
        word_s      = word_r;
        word_s[8 * int'(byte_idx_r) +: 8] = rx_data;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_s = S_CNT_LO;
                else       state_s = state_r;
            end
            S_CNT_LO: begin
                if (xfer_s) state_s = S_CNT_HI;
                else        state_s = state_r;
            end
            S_CNT_HI: begin
                if (!xfer_s)                          state_s = state_r;
                else if (count_s == 16'd0)            state_s = S_CHECK;
                else if ({1'b0, count_s} > MAX_WORDS) state_s = S_ERROR;
                else                                  state_s = S_DATA;
            end
            S_DATA: begin
                if (xfer_s && last_byte_s && last_word_s) state_s = S_CHECK;
                else                                      state_s = state_r;
            end
            S_CHECK: begin
                if (!xfer_s)              state_s = state_r;
                else if (rx_data == csum_r) state_s = S_DONE;
                else                      state_s = S_ERROR;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_r <= S_IDLE;
        else       state_r <= state_s;
    end

    // Datapath: checksum, counters, word assembly and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r       <= 16'd0;
            csum_r        <= 8'd0;
            word_idx_r    <= '0;
            byte_idx_r    <= '0;
            word_r        <= '0;
            mem_write_r   <= 1'b0;
            mem_address_r <= '0;
            mem_data_r    <= '0;
            core_halt_r   <= 1'b1;
            load_done_r   <= 1'b0;
            load_error_r  <= 1'b0;
        end else begin
            mem_write_r  <= 1'b0;
            core_halt_r  <= (state_s != S_DONE);
            load_done_r  <= (state_s == S_DONE);
            load_error_r <= (state_s == S_ERROR);
            if (arm_s) begin
                count_r    <= 16'd0;
                csum_r     <= 8'd0;
                word_idx_r <= '0;
                byte_idx_r <= '0;
                word_r     <= '0;
            end else if (xfer_s) begin
                case (state_r)
                    S_CNT_LO: begin
                        count_r[7:0] <= rx_data;
                        csum_r       <= csum_r ^ rx_data;
                    end
                    S_CNT_HI: begin
                        count_r <= count_s;
                        csum_r  <= csum_r ^ rx_data;
                    end
                    S_DATA: begin
                        csum_r <= csum_r ^ rx_data;
                        word_r <= word_s;
                        if (last_byte_s) begin
                            byte_idx_r    <= '0;
                            mem_write_r   <= 1'b1;
                            mem_address_r <= word_idx_r;
                            mem_data_r    <= word_s;
                            word_idx_r    <= word_idx_r + ADDR_WIDTH'(1);
                        end else begin
                            byte_idx_r <= byte_idx_r + BIDX_W'(1);
                        end
                    end
                    default: begin
                        csum_r <= csum_r;
                    end
                endcase
            end else begin
                csum_r <= csum_r;
            end
        end
    end

    assign rx_ready    = rx_ready_s;
    assign mem_write   = mem_write_r;
    assign mem_address = mem_address_r;
    assign mem_data    = mem_data_r;
    assign core_halt   = core_halt_r;
    assign load_done   = load_done_r;
    assign load_error  = load_error_r;

endmodule
